// File: rtl/key_debounce_pkg.sv
// Shared types and helpers for the push-button debouncer.
package key_debounce_pkg;

  typedef enum logic {DB_STABLE, DB_COUNTING} db_state_t;

  // Counter width for a given stable-cycle requirement, never narrower than one bit.
  function automatic int cnt_width(int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One push-button channel: 2-FF synchronizer, counter debounce, level and 1-cycle edge pulses.
module debounce_channel
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic key_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic          RAW_IDLE = ACTIVE_LOW;

  logic          s1;
  logic          s2;
  logic          norm;
  logic          differs;
  logic [CW-1:0] cnt;
  db_state_t     state;

  assign norm    = ACTIVE_LOW ? ~s2 : s2;
  assign differs = (norm != key_level);

  // The first differing cycle counts as 1, so acceptance lands DEBOUNCE_CYCLES edges after
  // the synchronized change; CNT_MAX == 0 accepts on that first cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1          <= RAW_IDLE;
      s2          <= RAW_IDLE;
      state       <= DB_STABLE;
      cnt         <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      s1          <= key_raw;
      s2          <= s1;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      unique case (state)
        DB_STABLE: begin
          cnt <= '0;
          if (differs) begin
            if (cnt == CNT_MAX) begin
              key_level   <= norm;
              key_press   <= norm;
              key_release <= ~norm;
            end else begin
              state <= DB_COUNTING;
              cnt   <= {{(CW-1){1'b0}}, 1'b1};
            end
          end
        end
        DB_COUNTING: begin
          if (!differs) begin
            state <= DB_STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state       <= DB_STABLE;
            cnt         <= '0;
            key_level   <= norm;
            key_press   <= norm;
            key_release <= ~norm;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debounce_sync.sv
// Debounced push-button block for the SoC push PIO; WIDTH independent channels.
// Optional sticky press capture is enabled by defining KEY_DEBOUNCE_EDGE_CAPTURE_EN.
module key_debounce_sync
  import key_debounce_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] key_level,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release,
  input  logic [WIDTH-1:0] edge_clear,
  output logic [WIDTH-1:0] edge_capture
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .Clk        (Clk),
      .Reset      (Reset),
      .key_raw    (key_raw[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i])
    );
  end

`ifdef KEY_DEBOUNCE_EDGE_CAPTURE_EN
  // A press arriving with a clear wins, so no press is ever lost to a software clear.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= (edge_capture & ~edge_clear) | key_press;
    end
  end
`else
  logic unused_edge_clear;
  assign unused_edge_clear = ^edge_clear;
  assign edge_capture      = '0;
`endif

endmodule

// File: tb/tb_key_debounce_sync.sv
// Directed bench for key_debounce_sync (DEBOUNCE_CYCLES = 8, WIDTH = 2, active-low keys).
module tb_key_debounce_sync;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [1:0] key_raw;
  logic [1:0] key_level;
  logic [1:0] key_press;
  logic [1:0] key_release;
  logic [1:0] edge_clear;
  logic [1:0] edge_capture;

  int checks = 0;
  int errors = 0;
  logic [1:0] pulses_seen;

  key_debounce_sync #(
    .WIDTH          (2),
    .DEBOUNCE_CYCLES(8),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .key_raw     (key_raw),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .edge_clear  (edge_clear),
    .edge_capture(edge_capture)
  );

  always #5 Clk = ~Clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Advance while recording any press/release pulse.
  task automatic tick_watch(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
      pulses_seen = pulses_seen | key_press | key_release;
    end
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] cap_exp(input logic [1:0] v);
`ifdef KEY_DEBOUNCE_EDGE_CAPTURE_EN
    return v;
`else
    return 2'b00;
`endif
  endfunction

  initial begin
    Reset      = 1'b1;
    key_raw    = 2'b11;
    edge_clear = 2'b00;
    tick(3);
    chk("rst_level", key_level, 2'b00);
    chk("rst_press", key_press, 2'b00);
    chk("rst_release", key_release, 2'b00);
    chk("rst_cap", edge_capture, 2'b00);
    Reset = 1'b0;
    tick(2);

    // Clean press on channel 0
    key_raw = 2'b10;
    tick(9);
    chk("press_level_early", key_level, 2'b00);
    chk("press_pulse_early", key_press, 2'b00);
    tick(1);
    chk("press_level", key_level, 2'b01);
    chk("press_pulse", key_press, 2'b01);
    chk("press_no_release", key_release, 2'b00);
    tick(1);
    chk("press_pulse_end", key_press, 2'b00);
    chk("press_level_hold", key_level, 2'b01);
    chk("cap_set", edge_capture, cap_exp(2'b01));

    // Bouncing channel 1 never accumulates 8 stable cycles
    pulses_seen = 2'b00;
    key_raw[1] = 1'b0;
    tick_watch(5);
    key_raw[1] = 1'b1;
    tick_watch(1);
    key_raw[1] = 1'b0;
    tick_watch(5);
    key_raw[1] = 1'b1;
    tick_watch(12);
    chk("bounce_level", key_level, 2'b01);
    chk("bounce_pulses", pulses_seen, 2'b00);
    chk("cap_held", edge_capture, cap_exp(2'b01));

    edge_clear = 2'b01;
    tick(1);
    edge_clear = 2'b00;
    chk("cap_clear", edge_capture, 2'b00);

    // Release channel 0
    key_raw = 2'b11;
    tick(9);
    chk("release_level_early", key_level, 2'b01);
    tick(1);
    chk("release_pulse", key_release, 2'b01);
    chk("release_level", key_level, 2'b00);
    chk("release_no_press", key_press, 2'b00);
    tick(1);
    chk("release_pulse_end", key_release, 2'b00);

    // Simultaneous press; clear coincident with the press pulse loses to the set
    key_raw = 2'b00;
    tick(10);
    chk("simul_press", key_press, 2'b11);
    chk("simul_level", key_level, 2'b11);
    chk("simul_no_release", key_release, 2'b00);
    edge_clear = 2'b11;
    tick(1);
    edge_clear = 2'b00;
    chk("cap_set_wins", edge_capture, cap_exp(2'b11));

    // Asynchronous reset mid-cycle clears without a clock edge
    #3;
    Reset = 1'b1;
    #1;
    chk("async_level", key_level, 2'b00);
    chk("async_cap", edge_capture, 2'b00);
    tick(1);
    Reset   = 1'b0;
    key_raw = 2'b11;
    tick(3);
    chk("post_rst_level", key_level, 2'b00);

    // Reset at count 4 discards the partial count
    key_raw = 2'b00;
    tick(6);
    chk("midcount_level", key_level, 2'b00);
    Reset = 1'b1;
    tick(1);
    chk("midcount_rst_press", key_press, 2'b00);
    Reset = 1'b0;
    tick(9);
    chk("restart_level_early", key_level, 2'b00);
    chk("restart_press_early", key_press, 2'b00);
    tick(1);
    chk("restart_press", key_press, 2'b11);
    chk("restart_level", key_level, 2'b11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
